// File: rtl/modexp_seq_if.sv
// modexp_seq_if: host start/busy/done bus plus the
// req/ack bus toward the shared modular multiplier.
interface modexp_seq_if #(
  parameter int WIDTH = 64,
  parameter int EBITS = 8
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] modulus;
  logic [EBITS-1:0] exp;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             trig;
  logic             mm_req;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_n;
  logic             mm_ack;
  logic [WIDTH-1:0] mm_p;

  modport master (
    output start, base, modulus, exp,
    output mm_ack, mm_p,
    input  busy, done, result, trig,
    input  mm_req, mm_a, mm_b, mm_n
  );

  modport slave (
    input  start, base, modulus, exp,
    input  mm_ack, mm_p,
    output busy, done, result, trig,
    output mm_req, mm_a, mm_b, mm_n
  );
endinterface

// File: rtl/modexp_seq.sv
// modexp_seq: left-to-right square-and-multiply sequencer.
// MODEXP_DUMMY_MUL_EN: always issue the multiply (constant time).
module modexp_seq #(
  parameter int WIDTH = 64,
  parameter int EBITS = 8
) (
  input logic         clk,
  input logic         rst,
  modexp_seq_if.slave bus
);

  localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(EBITS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef MODEXP_DUMMY_MUL_EN
  localparam logic DUMMY = 1'b1;
`else
  localparam logic DUMMY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_MUL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [EBITS-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             trig_q, trig_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cur_bit;

  assign cur_bit = exp_q[idx_q];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    mod_d    = mod_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    trig_d   = 1'b0;
    req_d    = req_q;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SQR;
          base_d  = bus.base;
          mod_d   = bus.modulus;
          exp_d   = bus.exp;
          acc_d   = ONE;
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          trig_d  = 1'b1;
          req_d   = 1'b1;
          a_d     = ONE;
          b_d     = ONE;
        end
      end
      S_SQR: begin
        if (bus.mm_ack) begin
          acc_d = bus.mm_p;
          if (cur_bit || DUMMY) begin
            state_d = S_MUL;
            a_d     = bus.mm_p;
            b_d     = base_q;
          end else begin
            state_d = S_NEXT;
            req_d   = 1'b0;
          end
        end
      end
      S_MUL: begin
        if (bus.mm_ack) begin
          // a dummy product for a zero bit is dropped
          if (cur_bit) begin
            acc_d = bus.mm_p;
          end
          state_d = S_NEXT;
          req_d   = 1'b0;
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = acc_q;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SQR;
          req_d   = 1'b1;
          a_d     = acc_q;
          b_d     = acc_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= ONE;
      base_q   <= '0;
      mod_q    <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      trig_q   <= 1'b0;
      req_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      trig_q   <= trig_d;
      req_q    <= req_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.trig   = trig_q;
  assign bus.mm_req = req_q;
  assign bus.mm_a   = a_q;
  assign bus.mm_b   = b_q;
  assign bus.mm_n   = mod_q;

endmodule

// File: tb/tb_modexp_seq.sv
// tb_modexp_seq: directed vectors against a bench
// multiplier that acks one cycle after seeing req.
module tb_modexp_seq;

  localparam int W = 64;
  localparam int E = 8;

`ifdef MODEXP_DUMMY_MUL_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  initial forever #5 clk = ~clk;

  modexp_seq_if #(.WIDTH(W), .EBITS(E)) ifc ();

  modexp_seq #(.WIDTH(W), .EBITS(E)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [63:0] n);
    logic [127:0] t;
    if (n == 64'd0) return 64'd0;
    t = {64'd0, a} * {64'd0, b};
    t = t % {64'd0, n};
    return t[63:0];
  endfunction

  // bench multiplier
  logic        ack_q = 1'b0;
  logic [63:0] p_q = 64'd0;
  int          wc = 0;
  int          stall = 0;
  int          ack_limit = 1 << 30;
  int          ack_total = 0;
  logic        force_ack = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      wc    <= 0;
    end else if (ifc.mm_req && !ack_q && ack_total < ack_limit) begin
      if (wc < stall) begin
        wc <= wc + 1;
      end else begin
        ack_q     <= 1'b1;
        wc        <= 0;
        ack_total <= ack_total + 1;
        p_q       <= mulmod(ifc.mm_a, ifc.mm_b, ifc.mm_n);
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  assign ifc.mm_ack = ack_q | force_ack;
  assign ifc.mm_p   = force_ack ? 64'hdeadbeefcafef00d : p_q;

  // monitor: req/ack pairs, trig pulses, operand stability
  int          pairs_tot = 0;
  int          trig_tot = 0;
  int          stab_tot = 0;
  bit          in_op = 1'b0;
  logic [63:0] a0 = 64'd0;
  logic [63:0] b0 = 64'd0;

  always @(negedge clk) begin
    if (ifc.trig) trig_tot <= trig_tot + 1;
    if (ifc.mm_req && ifc.mm_ack) pairs_tot <= pairs_tot + 1;
    if (!ifc.mm_req) begin
      in_op <= 1'b0;
    end else begin
      if (!in_op) begin
        a0 <= ifc.mm_a;
        b0 <= ifc.mm_b;
        in_op <= !ifc.mm_ack;
      end else begin
        if (ifc.mm_a !== a0 || ifc.mm_b !== b0)
          stab_tot <= stab_tot + 1;
        if (ifc.mm_ack) in_op <= 1'b0;
      end
    end
  end

  task automatic run(input logic [63:0] b,
                     input logic [63:0] n,
                     input logic [7:0]  e,
                     input bit          hold,
                     output logic [63:0] res,
                     output int          lat,
                     output int          pairs,
                     output int          trigs);
    int p0;
    int t0;
    @(negedge clk);
    p0 = pairs_tot;
    t0 = trig_tot;
    ifc.base    = b;
    ifc.modulus = n;
    ifc.exp     = e;
    ifc.start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) ifc.start = 1'b0;
    ifc.base    = ~b;
    ifc.modulus = ~n;
    ifc.exp     = ~e;
    lat = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("busy_c1", 64'(ifc.busy), 64'd1);
        check("trig_c1", 64'(ifc.trig), 64'd1);
      end
      if (ifc.done) begin
        lat = i;
        break;
      end
    end
    check("done_seen", 64'(lat != 0), 64'd1);
    #1;
    res   = ifc.result;
    pairs = pairs_tot - p0;
    trigs = trig_tot - t0;
  endtask

  logic [63:0] res;
  logic [63:0] gold;
  int          lat;
  int          pairs;
  int          trigs;
  int          s0;

  initial begin
    rst = 1'b1;
    ifc.start   = 1'b0;
    ifc.base    = '0;
    ifc.modulus = '0;
    ifc.exp     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(ifc.busy), 64'd0);
    check("rst_done", 64'(ifc.done), 64'd0);
    check("rst_trig", 64'(ifc.trig), 64'd0);
    check("rst_req", 64'(ifc.mm_req), 64'd0);
    check("rst_result", ifc.result, 64'd0);
    rst = 1'b0;

    // 3^5 mod 7 = 243 mod 7 = 5
    run(64'd3, 64'd7, 8'h05, 1'b0, res, lat, pairs, trigs);
    check("t1_result", res, 64'd5);
    check("t1_lat", 64'(lat), DUMMY ? 64'd41 : 64'd29);
    check("t1_pairs", 64'(pairs), DUMMY ? 64'd16 : 64'd10);
    check("t1_trigs", 64'(trigs), 64'd1);
    repeat (3) @(negedge clk);
    check("t1_hold", ifc.result, 64'd5);
    check("t1_idle", 64'(ifc.busy), 64'd0);

    // exp=0 yields 1
    run(64'd9, 64'd11, 8'h00, 1'b0, res, lat, pairs, trigs);
    check("t2_result", res, 64'd1);
    check("t2_lat", 64'(lat), DUMMY ? 64'd41 : 64'd25);
    check("t2_pairs", 64'(pairs), DUMMY ? 64'd16 : 64'd8);

    // wide operands, not pre-reduced
    gold = 64'd1;
    for (int i = 0; i < 240; i++)
      gold = mulmod(gold, 64'hf01f2e724ac0ab35, 64'hbe3a20ff7a7d7fca);
    run(64'hf01f2e724ac0ab35, 64'hbe3a20ff7a7d7fca, 8'hF0, 1'b0,
        res, lat, pairs, trigs);
    check("t3_result", res, gold);
    check("t3_lat", 64'(lat), DUMMY ? 64'd41 : 64'd33);
    check("t3_trigs", 64'(trigs), 64'd1);
    check("t3_pairs", 64'(pairs), DUMMY ? 64'd16 : 64'd12);

    // start held high: one op, re-accept only from IDLE
    run(64'd3, 64'd7, 8'h05, 1'b1, res, lat, pairs, trigs);
    check("t4_result", res, 64'd5);
    check("t4_trigs", 64'(trigs), 64'd1);
    check("t4_lat", 64'(lat), DUMMY ? 64'd41 : 64'd29);
    ifc.base    = 64'd2;
    ifc.modulus = 64'd13;
    ifc.exp     = 8'h03;
    @(negedge clk);
    check("t4_idle_busy", 64'(ifc.busy), 64'd0);
    @(negedge clk);
    check("t4_reacc_busy", 64'(ifc.busy), 64'd1);
    check("t4_reacc_trig", 64'(ifc.trig), 64'd1);
    ifc.start = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        lat = 1;
        break;
      end
    end
    check("t4_done2", 64'(lat), 64'd1);
    // 2^3 mod 13 = 8
    check("t4_result2", ifc.result, 64'd8);

    // reset during the 3rd MUL, then a stray ack
    @(negedge clk);
    ack_limit = ack_total + 5;
    ifc.base    = 64'd3;
    ifc.modulus = 64'd7;
    ifc.exp     = 8'hFF;
    ifc.start   = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack_total >= ack_limit) break;
    end
    repeat (3) @(negedge clk);
    check("t5_mul3_req", 64'(ifc.mm_req), 64'd1);
    check("t5_mul3_b", ifc.mm_b, 64'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_ack = 1'b1;
    check("t5_busy", 64'(ifc.busy), 64'd0);
    check("t5_req", 64'(ifc.mm_req), 64'd0);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    ack_limit = 1 << 30;
    check("t5_busy2", 64'(ifc.busy), 64'd0);
    check("t5_req2", 64'(ifc.mm_req), 64'd0);
    check("t5_done2", 64'(ifc.done), 64'd0);
    check("t5_result", ifc.result, 64'd0);
    check("t5_acc", dut.acc_q, 64'd1);
    // 5^7 mod 11: 5^2=3, 5^4=9, 5^7=9*3*5=135 mod 11 = 3
    run(64'd5, 64'd11, 8'h07, 1'b0, res, lat, pairs, trigs);
    check("t5_fresh", res, 64'd3);

    // stalled multiplier: C = 22
    stall = 20;
    s0 = stab_tot;
    run(64'd3, 64'd7, 8'h05, 1'b0, res, lat, pairs, trigs);
    #1;
    check("t6_result", res, 64'd5);
    check("t6_lat", 64'(lat), DUMMY ? 64'd361 : 64'd229);
    check("t6_stable", 64'(stab_tot - s0), 64'd0);
    stall = 0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
